// File: rtl/dct_2d_core.sv
// dct_2d_core: 8x8 forward 2-D integer DCT. A row pass and then a column pass share one
// array of 64 signed multipliers; results are exact (no rounding between passes).
//
// Ports:
//   clk           system clock, rising edge
//   rst_n         asynchronous active-low reset (deassertion synchronized internally)
//   start_block   start request; in IDLE it latches the 64 samples of block
//   block         input samples, block[r][c] = row r, column c, signed 9-bit
//   dct_block_out registered coefficients, dct_block_out[v][u], signed 52-bit
//   block_done    one-cycle pulse in the first cycle a new result is visible
//
// Build option: define DCT_2D_RESTART_EN to let start_block abort and restart a block that
// is in flight. Without it, starts while busy are ignored.
module dct_2d_core (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start_block,
  input  logic signed [7:0][7:0][8:0]   block,
  output logic signed [7:0][7:0][51:0]  dct_block_out,
  output logic                          block_done
);

  typedef enum logic [1:0] {StIdle, StRow, StCol, StDone} state_e;

  // Coefficient C[u][x] = round(16384 * a(u) * cos((2x+1)*u*pi/16)).
  function automatic logic signed [15:0] coef(input logic [2:0] u, input logic [2:0] x);
    logic [6:0]         ang;
    logic [4:0]         k;
    logic [3:0]         m;
    logic               neg;
    logic signed [15:0] mag;
    ang = {3'b000, x, 1'b1} * {4'b0000, u};
    k   = ang[4:0];                       // angle modulo 2*pi, in units of pi/16
    if (k > 5'd16) k = 5'd32 - k;         // cos is even about pi
    neg = (k > 5'd8);
    m   = neg ? 4'(5'd16 - k) : k[3:0];   // cos(pi - a) = -cos(a)
    case (m)
      4'd0:    mag = 16'sd8192;
      4'd1:    mag = 16'sd8035;
      4'd2:    mag = 16'sd7568;
      4'd3:    mag = 16'sd6811;
      4'd4:    mag = 16'sd5793;
      4'd5:    mag = 16'sd4551;
      4'd6:    mag = 16'sd3135;
      4'd7:    mag = 16'sd1598;
      default: mag = 16'sd0;
    endcase
    if (u == 3'd0) return 16'sd5793;
    return neg ? -mag : mag;
  endfunction

  // Reset synchronizer: asserts asynchronously, releases two clock edges later.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  state_e state_q, state_d;
  logic [2:0] u_q, u_d;
  logic [7:0][7:0][8:0]  blk_q;   // captured samples [r][x]
  logic [7:0][7:0][27:0] t_q;     // row-pass results T[r][u]
  logic [7:0][7:0][46:0] f_q;     // column-pass results F[v][u]
  logic load_blk, write_t, write_f, write_out;

  always_comb begin
    state_d   = state_q;
    u_d       = u_q;
    load_blk  = 1'b0;
    write_t   = 1'b0;
    write_f   = 1'b0;
    write_out = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_block) begin
          load_blk = 1'b1;
          u_d      = 3'd0;
          state_d  = StRow;
        end
      end
      StRow: begin
        write_t = 1'b1;
        u_d     = u_q + 3'd1;
        if (u_q == 3'd7) state_d = StCol;
      end
      StCol: begin
        write_f = 1'b1;
        u_d     = u_q + 3'd1;
        if (u_q == 3'd7) state_d = StDone;
      end
      StDone: begin
        write_out = 1'b1;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
`ifdef DCT_2D_RESTART_EN
    // A busy start abandons the pass in progress; a finished block still gets written.
    if (start_block && (state_q != StIdle)) begin
      load_blk = 1'b1;
      write_t  = 1'b0;
      write_f  = 1'b0;
      u_d      = 3'd0;
      state_d  = StRow;
    end
`endif
  end

  // Shared multiplier array. Row pass: i = r, j = x. Column pass: i = v, j = r.
  logic signed [27:0] op_a [8][8];
  logic signed [15:0] op_c [8][8];
  logic signed [43:0] prod [8][8];
  logic signed [46:0] acc  [8];

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      acc[i] = '0;
      for (int j = 0; j < 8; j++) begin
        if (state_q == StRow) begin
          op_a[i][j] = {{19{blk_q[i][j][8]}}, blk_q[i][j]};
          op_c[i][j] = coef(u_q, 3'(j));
        end else begin
          op_a[i][j] = t_q[j][u_q];
          op_c[i][j] = coef(3'(i), 3'(j));
        end
        prod[i][j] = op_a[i][j] * op_c[i][j];
        acc[i]     = acc[i] + {{3{prod[i][j][43]}}, prod[i][j]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q       <= StIdle;
      u_q           <= 3'd0;
      blk_q         <= '0;
      t_q           <= '0;
      f_q           <= '0;
      dct_block_out <= '0;
      block_done    <= 1'b0;
    end else begin
      state_q    <= state_d;
      u_q        <= u_d;
      block_done <= write_out;
      if (load_blk) blk_q <= block;
      if (write_t) begin
        for (int i = 0; i < 8; i++) t_q[i][u_q] <= acc[i][27:0];
      end
      if (write_f) begin
        for (int i = 0; i < 8; i++) f_q[i][u_q] <= acc[i];
      end
      if (write_out) begin
        for (int v = 0; v < 8; v++) begin
          for (int u = 0; u < 8; u++) begin
            dct_block_out[v][u] <= {{5{f_q[v][u][46]}}, f_q[v][u]};
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_dct_2d_core.sv
module tb_dct_2d_core;

  logic                         clk;
  logic                         rst_n;
  logic                         start_block;
  logic signed [7:0][7:0][8:0]  block;
  logic signed [7:0][7:0][51:0] dout;
  logic                         block_done;

  dct_2d_core dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_block   (start_block),
    .block         (block),
    .dct_block_out (dout),
    .block_done    (block_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DCT_2D_RESTART_EN
  localparam int HeldDoneEdge = 29;
`else
  localparam int HeldDoneEdge = 17;
`endif

  int     total;
  int     passed;
  int     cf    [8][8];
  int     cur   [8][8];
  longint exp_m [8][8];
  longint exp_a [8][8];
  longint exp_b [8][8];
  logic signed [51:0] got;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Coefficients straight from the cosine definition.
  task automatic build_coefs();
    real pi, a, v;
    pi = 3.14159265358979323846;
    for (int u = 0; u < 8; u++) begin
      for (int x = 0; x < 8; x++) begin
        a = (u == 0) ? $sqrt(1.0 / 8.0) : 0.5;
        v = 16384.0 * a * $cos(real'((2 * x + 1) * u) * pi / 16.0);
        cf[u][x] = $rtoi((v >= 0.0) ? v + 0.5 : v - 0.5);
      end
    end
  endtask

  // F = C * X * C^T in plain 64-bit arithmetic.
  task automatic compute_expected();
    longint t [8][8];
    for (int r = 0; r < 8; r++) begin
      for (int u = 0; u < 8; u++) begin
        t[r][u] = 0;
        for (int x = 0; x < 8; x++) t[r][u] += longint'(cur[r][x]) * longint'(cf[u][x]);
      end
    end
    for (int v = 0; v < 8; v++) begin
      for (int u = 0; u < 8; u++) begin
        exp_m[v][u] = 0;
        for (int r = 0; r < 8; r++) exp_m[v][u] += longint'(cf[v][r]) * t[r][u];
      end
    end
  endtask

  task automatic fill_const(input int val);
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) cur[r][c] = val;
  endtask

  task automatic fill_random();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) cur[r][c] = int'($urandom_range(511)) - 256;
  endtask

  task automatic drive_cur();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) block[r][c] = 9'(cur[r][c]);
  endtask

  task automatic drive_garbage();
    for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) block[r][c] = 9'($urandom);
  endtask

  // Pulse start with cur; returns edges from acceptance to block_done (0 on timeout).
  task automatic run_block(output int lat);
    drive_cur();
    start_block = 1'b1;
    tick();
    start_block = 1'b0;
    drive_garbage();
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (block_done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (block_done !== 1'b0) $display("FAIL reset_done got %b want 0", block_done);
    else passed++;
    total++;
    if (dout !== '0) $display("FAIL reset_out got nonzero want 0");
    else passed++;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_zero_block();
    int lat;
    fill_const(0);
    compute_expected();
    run_block(lat);
    total++;
    if (lat != 17) $display("FAIL zero_latency got %0d want 17", lat);
    else passed++;
    for (int v = 0; v < 8; v++) for (int u = 0; u < 8; u++) begin
      got = dout[v][u];
      total++;
      if (got !== 52'(exp_m[v][u]))
        $display("FAIL zero F[%0d][%0d] got %0d want %0d", v, u, got, exp_m[v][u]);
      else passed++;
    end
    tick();
    total++;
    if (block_done !== 1'b0) $display("FAIL done_width got %b want 0", block_done);
    else passed++;
  endtask

  task automatic test_constant();
    int     vals [4];
    longint dc   [4];
    int     lat;
    vals = '{1, -1, 255, -256};
    dc   = '{64'sd2147766336, -64'sd2147766336, 64'sd547680415680, -64'sd549828182016};
    for (int i = 0; i < 4; i++) begin
      fill_const(vals[i]);
      compute_expected();
      run_block(lat);
      total++;
      if (lat != 17) $display("FAIL const%0d_latency got %0d want 17", vals[i], lat);
      else passed++;
      got = dout[0][0];
      total++;
      if (got !== 52'(dc[i])) $display("FAIL const%0d_dc got %0d want %0d", vals[i], got, dc[i]);
      else passed++;
      for (int v = 0; v < 8; v++) for (int u = 0; u < 8; u++) begin
        got = dout[v][u];
        total++;
        if (got !== 52'(exp_m[v][u]))
          $display("FAIL const%0d F[%0d][%0d] got %0d want %0d", vals[i], v, u, got, exp_m[v][u]);
        else passed++;
      end
    end
  endtask

  task automatic test_impulse();
    int lat;
    fill_const(0);
    cur[0][0] = 1;
    compute_expected();
    run_block(lat);
    total++;
    if (lat != 17) $display("FAIL impulse_latency got %0d want 17", lat);
    else passed++;
    got = dout[0][0];
    total++;
    if (got !== 52'sd33558849) $display("FAIL impulse_00 got %0d want 33558849", got);
    else passed++;
    got = dout[0][1];
    total++;
    if (got !== 52'sd46546755) $display("FAIL impulse_01 got %0d want 46546755", got);
    else passed++;
    got = dout[1][0];
    total++;
    if (got !== 52'sd46546755) $display("FAIL impulse_10 got %0d want 46546755", got);
    else passed++;
    for (int v = 0; v < 8; v++) for (int u = 0; u < 8; u++) begin
      got = dout[v][u];
      total++;
      if (got !== 52'(exp_m[v][u]))
        $display("FAIL impulse F[%0d][%0d] got %0d want %0d", v, u, got, exp_m[v][u]);
      else passed++;
    end
  endtask

  task automatic test_random();
    int lat;
    for (int n = 0; n < 4; n++) begin
      fill_random();
      compute_expected();
      run_block(lat);
      total++;
      if (lat != 17) $display("FAIL random%0d_latency got %0d want 17", n, lat);
      else passed++;
      for (int v = 0; v < 8; v++) for (int u = 0; u < 8; u++) begin
        got = dout[v][u];
        total++;
        if (got !== 52'(exp_m[v][u]))
          $display("FAIL random%0d F[%0d][%0d] got %0d want %0d", n, v, u, got, exp_m[v][u]);
        else passed++;
      end
    end
  endtask

  // Start held for two edges, then a second start in the middle of the column pass.
  task automatic test_held_restart();
    int first_done;
    int n_done;
    fill_random();
    compute_expected();
    exp_a = exp_m;
    drive_cur();
    start_block = 1'b1;
    tick();
    tick();
    start_block = 1'b0;
    drive_garbage();
    first_done = 0;
    n_done     = 0;
    for (int e = 2; e <= 60; e++) begin
      if (e == 12) begin
        fill_random();
        compute_expected();
        exp_b = exp_m;
        drive_cur();
        start_block = 1'b1;
      end
      tick();
      if (e == 12) begin
        start_block = 1'b0;
        drive_garbage();
      end
      if (block_done) begin
        n_done++;
        if (first_done == 0) begin
          first_done = e;
          for (int v = 0; v < 8; v++) for (int u = 0; u < 8; u++) begin
            got = dout[v][u];
            total++;
`ifdef DCT_2D_RESTART_EN
            if (got !== 52'(exp_b[v][u]))
              $display("FAIL held F[%0d][%0d] got %0d want %0d", v, u, got, exp_b[v][u]);
`else
            if (got !== 52'(exp_a[v][u]))
              $display("FAIL held F[%0d][%0d] got %0d want %0d", v, u, got, exp_a[v][u]);
`endif
            else passed++;
          end
        end
      end
    end
    total++;
    if (first_done != HeldDoneEdge)
      $display("FAIL held_done_edge got %0d want %0d", first_done, HeldDoneEdge);
    else passed++;
    total++;
    if (n_done != 1) $display("FAIL held_done_count got %0d want 1", n_done);
    else passed++;
  endtask

  task automatic test_reset_mid_row();
    int lat;
    int n_done;
    fill_random();
    drive_cur();
    start_block = 1'b1;
    tick();
    start_block = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    total++;
    if (dout !== '0) $display("FAIL midrow_out got nonzero want 0");
    else passed++;
    total++;
    if (block_done !== 1'b0) $display("FAIL midrow_done got %b want 0", block_done);
    else passed++;
    repeat (2) tick();
    rst_n  = 1'b1;
    n_done = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (block_done) n_done++;
    end
    total++;
    if (n_done != 0) $display("FAIL midrow_no_done got %0d want 0", n_done);
    else passed++;
    fill_random();
    compute_expected();
    run_block(lat);
    total++;
    if (lat != 17) $display("FAIL after_reset_latency got %0d want 17", lat);
    else passed++;
    for (int v = 0; v < 8; v++) for (int u = 0; u < 8; u++) begin
      got = dout[v][u];
      total++;
      if (got !== 52'(exp_m[v][u]))
        $display("FAIL after_reset F[%0d][%0d] got %0d want %0d", v, u, got, exp_m[v][u]);
      else passed++;
    end
  endtask

  task automatic test_back_to_back();
    int d1;
    int d2;
    int n_done;
    fill_random();
    compute_expected();
    exp_a = exp_m;
    drive_cur();
    fill_random();
    compute_expected();
    exp_b = exp_m;
    start_block = 1'b1;
    tick();
    start_block = 1'b0;
    drive_garbage();
    d1 = 0;
    d2 = 0;
    n_done = 0;
    for (int e = 1; e <= 40; e++) begin
      if (e == 18) begin
        drive_cur();
        start_block = 1'b1;
      end
      tick();
      if (e == 18) begin
        start_block = 1'b0;
        drive_garbage();
      end
      if (block_done) begin
        n_done++;
        if (d1 == 0) d1 = e;
        else if (d2 == 0) d2 = e;
      end
      if (e == 17 || e == 34 || e == 35) begin
        for (int v = 0; v < 8; v++) for (int u = 0; u < 8; u++) begin
          got = dout[v][u];
          total++;
          if (e == 35) begin
            if (got !== 52'(exp_b[v][u]))
              $display("FAIL b2b_e%0d F[%0d][%0d] got %0d want %0d", e, v, u, got, exp_b[v][u]);
            else passed++;
          end else begin
            if (got !== 52'(exp_a[v][u]))
              $display("FAIL b2b_e%0d F[%0d][%0d] got %0d want %0d", e, v, u, got, exp_a[v][u]);
            else passed++;
          end
        end
      end
    end
    total++;
    if (d1 != 17) $display("FAIL b2b_first_done got %0d want 17", d1);
    else passed++;
    total++;
    if (d2 != 35) $display("FAIL b2b_second_done got %0d want 35", d2);
    else passed++;
    total++;
    if (n_done != 2) $display("FAIL b2b_done_count got %0d want 2", n_done);
    else passed++;
  endtask

  initial begin
    total       = 0;
    passed      = 0;
    rst_n       = 1'b1;
    start_block = 1'b0;
    block       = '0;
    build_coefs();
    test_reset();
    test_zero_block();
    test_constant();
    test_impulse();
    test_random();
    test_held_restart();
    test_reset_mid_row();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
